regstat_rat: RTL and testbench

Parametrised register status table (register alias table) for the issue stage. Maps each architectural register to the ROB tag of its youngest in-flight writer, for up to ISSUE_W instructions issued and COMMIT_W instructions committed per cycle. Keeps NUM_CKPT branch snapshots so a misprediction restores in one cycle without draining the ROB. Reports an explicit busy bit per source operand, so ROB tag 0 is a legal tag.

---
 rtl/regstat_pkg.sv | 22 ++
 rtl/regstat_snapshot_bank.sv | 65 ++++++
 rtl/regstat_rat.sv | 144 ++++++++++++++
 tb/tb_regstat_rat.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/regstat_pkg.sv
// Shared types and width helpers for the register status table.
// Tags are stored zero-extended to MAX_TAG_W so one entry type serves any ROB depth up to 256.
package regstat_pkg;

    localparam int unsigned MAX_TAG_W = 8;

    typedef logic [MAX_TAG_W-1:0] rat_tag_t;

    typedef struct packed {
        logic     busy;
        rat_tag_t tag;
    } rat_entry_t;

    function automatic int unsigned tag_width(input int unsigned rob_depth);
        return (rob_depth > 1) ? $clog2(rob_depth) : 1;
    endfunction

    function automatic int unsigned ckpt_width(input int unsigned num_ckpt);
        return (num_ckpt > 1) ? $clog2(num_ckpt) : 1;
    endfunction

endpackage

// File: rtl/regstat_snapshot_bank.sv
// Branch snapshot storage: NUM_CKPT copies of the table, kept free of retired tags by
// applying every commit clear, with one capture port and one read-out port.
module regstat_snapshot_bank
    import regstat_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_CKPT = 4,
    parameter int unsigned COMMIT_W = 2,
    parameter int unsigned REG_W    = $clog2(NUM_REGS),
    parameter int unsigned CK_W     = ckpt_width(NUM_CKPT)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear_all,
    input  logic [COMMIT_W-1:0]            cm_valid,
    input  logic [COMMIT_W-1:0][REG_W-1:0] cm_rd,
    input  rat_tag_t                       cm_tag [COMMIT_W],
    input  logic                           take,
    input  logic [CK_W-1:0]                take_id,
    input  rat_entry_t                     take_data [NUM_REGS],
    input  logic [CK_W-1:0]                rd_id,
    output rat_entry_t                     rd_data [NUM_REGS]
);

    rat_entry_t snap_q [NUM_CKPT][NUM_REGS];
    rat_entry_t snap_c [NUM_CKPT][NUM_REGS];
    rat_entry_t snap_d [NUM_CKPT][NUM_REGS];

    always_comb begin
        snap_c = snap_q;
        for (int k = 0; k < NUM_CKPT; k++) begin
            for (int c = 0; c < COMMIT_W; c++) begin
                if (cm_valid[c] && snap_q[k][cm_rd[c]].busy &&
                    snap_q[k][cm_rd[c]].tag == cm_tag[c]) begin
                    snap_c[k][cm_rd[c]] = '0;
                end
            end
        end
    end

    always_comb begin
        snap_d = snap_c;
        if (take) begin
            snap_d[take_id] = take_data;
        end
    end

    // Read-out already carries this cycle's clears so a restore never resurrects a retired tag.
    always_comb begin
        rd_data = snap_c[rd_id];
    end

    always_ff @(posedge clk) begin
        if (reset || clear_all) begin
            for (int k = 0; k < NUM_CKPT; k++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    snap_q[k][r] <= '0;
                end
            end
        end else begin
            snap_q <= snap_d;
        end
    end

endmodule

// File: rtl/regstat_rat.sv
// Register alias table: maps each architectural register to its youngest in-flight ROB tag,
// with intra-bundle forwarding and single-cycle branch checkpoint restore.
module regstat_rat
    import regstat_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned ROB_DEPTH = 16,
    parameter int unsigned ISSUE_W   = 2,
    parameter int unsigned COMMIT_W  = 2,
    parameter int unsigned NUM_CKPT  = 4,
    parameter int unsigned TAG_W     = tag_width(ROB_DEPTH),
    parameter int unsigned CK_W      = ckpt_width(NUM_CKPT),
    parameter int unsigned REG_W     = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ISSUE_W-1:0]             iss_valid,
    input  logic [ISSUE_W-1:0]             iss_wr,
    input  logic [ISSUE_W-1:0][REG_W-1:0]  iss_rd,
    input  logic [ISSUE_W-1:0][REG_W-1:0]  iss_rs1,
    input  logic [ISSUE_W-1:0][REG_W-1:0]  iss_rs2,
    input  logic [ISSUE_W-1:0][TAG_W-1:0]  iss_tag,
    output logic [ISSUE_W-1:0]             src1_busy,
    output logic [ISSUE_W-1:0]             src2_busy,
    output logic [ISSUE_W-1:0][TAG_W-1:0]  src1_tag,
    output logic [ISSUE_W-1:0][TAG_W-1:0]  src2_tag,
    input  logic [COMMIT_W-1:0]            cm_valid,
    input  logic [COMMIT_W-1:0][REG_W-1:0] cm_rd,
    input  logic [COMMIT_W-1:0][TAG_W-1:0] cm_tag,
    input  logic                           ckpt_take,
    input  logic                           ckpt_restore,
    input  logic [CK_W-1:0]                ckpt_id,
    input  logic                           flush
);

    rat_entry_t table_q  [NUM_REGS];
    rat_entry_t table_nx [NUM_REGS];
    rat_entry_t table_d  [NUM_REGS];
    rat_entry_t snap_rd  [NUM_REGS];

    rat_tag_t             iss_tag_x [ISSUE_W];
    rat_tag_t             cm_tag_x  [COMMIT_W];
    logic [ISSUE_W-1:0]   iss_write;

    always_comb begin
        for (int i = 0; i < ISSUE_W; i++) begin
            iss_tag_x[i]            = '0;
            iss_tag_x[i][TAG_W-1:0] = iss_tag[i];
            iss_write[i]            = iss_valid[i] && iss_wr[i] && (iss_rd[i] != '0);
        end
        for (int c = 0; c < COMMIT_W; c++) begin
            cm_tag_x[c]            = '0;
            cm_tag_x[c][TAG_W-1:0] = cm_tag[c];
        end
    end

    // Clears first, then issue writes in slot order so the youngest writer wins.
    always_comb begin
        table_nx = table_q;
        for (int c = 0; c < COMMIT_W; c++) begin
            if (cm_valid[c] && table_q[cm_rd[c]].busy &&
                table_q[cm_rd[c]].tag == cm_tag_x[c]) begin
                table_nx[cm_rd[c]] = '0;
            end
        end
        for (int i = 0; i < ISSUE_W; i++) begin
            if (iss_write[i]) begin
                table_nx[iss_rd[i]].busy = 1'b1;
                table_nx[iss_rd[i]].tag  = iss_tag_x[i];
            end
        end
    end

    always_comb begin
        table_d = ckpt_restore ? snap_rd : table_nx;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                table_q[r] <= '0;
            end
        end else begin
            table_q <= table_d;
        end
    end

    regstat_snapshot_bank #(
        .NUM_REGS (NUM_REGS),
        .NUM_CKPT (NUM_CKPT),
        .COMMIT_W (COMMIT_W),
        .REG_W    (REG_W),
        .CK_W     (CK_W)
    ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .clear_all (flush),
        .cm_valid  (cm_valid),
        .cm_rd     (cm_rd),
        .cm_tag    (cm_tag_x),
        .take      (ckpt_take && !ckpt_restore),
        .take_id   (ckpt_id),
        .take_data (table_nx),
        .rd_id     (ckpt_id),
        .rd_data   (snap_rd)
    );

    logic [ISSUE_W-1:0]            b1, b2;
    logic [ISSUE_W-1:0][TAG_W-1:0] t1, t2;

    always_comb begin
        b1 = '0;
        b2 = '0;
        t1 = '0;
        t2 = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (iss_rs1[i] != '0) begin
                b1[i] = table_q[iss_rs1[i]].busy;
                t1[i] = table_q[iss_rs1[i]].tag[TAG_W-1:0];
                for (int j = 0; j < i; j++) begin
                    if (iss_write[j] && iss_rd[j] == iss_rs1[i]) begin
                        b1[i] = 1'b1;
                        t1[i] = iss_tag[j];
                    end
                end
            end
            if (iss_rs2[i] != '0) begin
                b2[i] = table_q[iss_rs2[i]].busy;
                t2[i] = table_q[iss_rs2[i]].tag[TAG_W-1:0];
                for (int j = 0; j < i; j++) begin
                    if (iss_write[j] && iss_rd[j] == iss_rs2[i]) begin
                        b2[i] = 1'b1;
                        t2[i] = iss_tag[j];
                    end
                end
            end
            src1_busy[i] = b1[i];
            src2_busy[i] = b2[i];
            src1_tag[i]  = b1[i] ? t1[i] : '0;
            src2_tag[i]  = b2[i] ? t2[i] : '0;
        end
    end

endmodule

// File: tb/tb_regstat_rat.sv
// Directed self-checking bench for regstat_rat with hand-computed expectations.
module tb_regstat_rat;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       iss_valid, iss_wr;
    logic [1:0][4:0]  iss_rd, iss_rs1, iss_rs2;
    logic [1:0][3:0]  iss_tag;
    logic [1:0]       src1_busy, src2_busy;
    logic [1:0][3:0]  src1_tag, src2_tag;
    logic [1:0]       cm_valid;
    logic [1:0][4:0]  cm_rd;
    logic [1:0][3:0]  cm_tag;
    logic             ckpt_take, ckpt_restore, flush;
    logic [1:0]       ckpt_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regstat_rat dut (
        .clk          (clk),
        .reset        (reset),
        .iss_valid    (iss_valid),
        .iss_wr       (iss_wr),
        .iss_rd       (iss_rd),
        .iss_rs1      (iss_rs1),
        .iss_rs2      (iss_rs2),
        .iss_tag      (iss_tag),
        .src1_busy    (src1_busy),
        .src2_busy    (src2_busy),
        .src1_tag     (src1_tag),
        .src2_tag     (src2_tag),
        .cm_valid     (cm_valid),
        .cm_rd        (cm_rd),
        .cm_tag       (cm_tag),
        .ckpt_take    (ckpt_take),
        .ckpt_restore (ckpt_restore),
        .ckpt_id      (ckpt_id),
        .flush        (flush)
    );

    task automatic idle();
        iss_valid = '0; iss_wr = '0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0; iss_tag = '0;
        cm_valid = '0; cm_rd = '0; cm_tag = '0;
        ckpt_take = 0; ckpt_restore = 0; ckpt_id = '0; flush = 0; reset = 0;
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 2 units after it.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(input int slot, input int rd, input int tag);
        iss_valid[slot] = 1'b1;
        iss_wr[slot]    = 1'b1;
        iss_rd[slot]    = rd[4:0];
        iss_tag[slot]   = tag[3:0];
    endtask

    task automatic commit(input int port, input int rd, input int tag);
        cm_valid[port] = 1'b1;
        cm_rd[port]    = rd[4:0];
        cm_tag[port]   = tag[3:0];
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Looks up a register through slot0/rs1 and slot1/rs2 with no issue activity.
    task automatic rd_check(input string name, input int r, input logic eb, input int et);
        iss_rs1[0] = r[4:0];
        iss_rs2[1] = r[4:0];
        #1;
        chk({name, ".b1"}, {31'b0, src1_busy[0]}, {31'b0, eb});
        chk({name, ".t1"}, {28'b0, src1_tag[0]}, et);
        chk({name, ".b2"}, {31'b0, src2_busy[1]}, {31'b0, eb});
        chk({name, ".t2"}, {28'b0, src2_tag[1]}, et);
        iss_rs1 = '0;
        iss_rs2 = '0;
    endtask

    initial begin
        idle();
        reset = 1;
        tick();
        tick();
        rd_check("reset_x5", 5, 0, 0);
        rd_check("reset_x31", 31, 0, 0);

        // Intra-bundle dependency
        issue(0, 5, 3);
        iss_rs1[1] = 5;
        iss_rs1[0] = 5;
        #1;
        chk("fwd_b", {31'b0, src1_busy[1]}, 1);
        chk("fwd_t", {28'b0, src1_tag[1]}, 3);
        chk("nofwd_old_slot", {31'b0, src1_busy[0]}, 0);
        tick();
        rd_check("x5_after", 5, 1, 3);

        // Writes to x0 are dropped and x0 never forwards
        issue(0, 0, 7);
        iss_rs1[1] = 0;
        #1;
        chk("x0_fwd", {31'b0, src1_busy[1]}, 0);
        tick();
        rd_check("x0", 0, 0, 0);

        // Stale commit
        issue(0, 7, 2);
        tick();
        issue(0, 7, 9);
        tick();
        commit(0, 7, 2);
        tick();
        rd_check("stale", 7, 1, 9);
        commit(1, 7, 9);
        tick();
        rd_check("x7_retired", 7, 0, 0);

        // Commit/issue collision, then same-bundle write ordering
        issue(0, 4, 1);
        tick();
        commit(0, 4, 1);
        issue(1, 4, 6);
        tick();
        rd_check("collide", 4, 1, 6);
        issue(0, 11, 12);
        issue(1, 11, 13);
        tick();
        rd_check("youngest", 11, 1, 13);

        // Checkpoint restore
        issue(0, 3, 4);
        tick();
        ckpt_take = 1; ckpt_id = 1;
        tick();
        issue(0, 3, 8);
        issue(1, 9, 10);
        tick();
        rd_check("x3_new", 3, 1, 8);
        commit(0, 3, 4);
        tick();
        rd_check("x3_kept", 3, 1, 8);
        ckpt_restore = 1; ckpt_id = 1;
        tick();
        rd_check("rst_x3", 3, 0, 0);
        rd_check("rst_x9", 9, 0, 0);
        rd_check("rst_x4", 4, 1, 6);

        // Restore with concurrent commit; snapshot 0 captures the same-cycle write of x2
        issue(0, 2, 5);
        ckpt_take = 1; ckpt_id = 0;
        tick();
        issue(0, 2, 14);
        tick();
        rd_check("x2_new", 2, 1, 14);
        ckpt_restore = 1; ckpt_id = 0;
        commit(0, 2, 5);
        issue(0, 6, 1);
        tick();
        rd_check("rc_x2", 2, 0, 0);
        rd_check("rc_x6_ignored", 6, 0, 0);
        rd_check("rc_x4", 4, 1, 6);

        // Take alongside restore is dropped: snapshot 2 remains empty
        ckpt_restore = 1; ckpt_take = 1; ckpt_id = 2;
        tick();
        rd_check("tr_x4", 4, 0, 0);
        issue(0, 4, 6);
        tick();
        ckpt_restore = 1; ckpt_id = 2;
        tick();
        rd_check("tr_again_x4", 4, 0, 0);

        // Flush then reset, each after filling x10..x19 with tags 0..9
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 5; k++) begin
                issue(0, 10 + 2 * k, 2 * k);
                issue(1, 11 + 2 * k, 2 * k + 1);
                if (k == 4) begin
                    ckpt_take = 1;
                    ckpt_id   = 3;
                end
                tick();
            end
            rd_check("fill_x10", 10, 1, 0);
            rd_check("fill_x19", 19, 1, 9);
            if (pass == 0) flush = 1;
            else reset = 1;
            tick();
            for (int r = 10; r < 20; r++) begin
                rd_check($sformatf("clr%0d_x%0d", pass, r), r, 0, 0);
            end
            for (int c = 0; c < 4; c++) begin
                ckpt_restore = 1; ckpt_id = c[1:0];
                tick();
                rd_check($sformatf("clr%0d_ck%0d_x10", pass, c), 10, 0, 0);
                rd_check($sformatf("clr%0d_ck%0d_x19", pass, c), 19, 0, 0);
                rd_check($sformatf("clr%0d_ck%0d_x5", pass, c), 5, 0, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
